// File: rtl/run_ctrl.sv
// Start/Ack launch responder: holds PC at the program base while Start is high, runs until done.
// Latency: Start rise -> PcLoad 1 cycle, Start fall -> Run 1 cycle, DoneInstr -> Ack 1 cycle.
// No backpressure: Start is a level request, and Ack is held until the next Start.
module run_ctrl #(
  parameter int PC_W     = 10,
  parameter int NUM_PROG = 3,
  parameter int P1_BASE  = 0,
  parameter int P2_BASE  = 256,
  parameter int P3_BASE  = 512,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             DoneInstr,
  output logic             Ack,
  output logic             Run,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcTarget,
  output logic [1:0]       ProgIdx,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;

  localparam logic [1:0] LAST_IDX = 2'(NUM_PROG - 1);

  // Program base decode. PcTarget is the only output that is not registered.
  always_comb begin
    PcTarget = PC_W'(P1_BASE);
    case (ProgIdx)
      2'd1:    PcTarget = PC_W'(P2_BASE);
      2'd2:    PcTarget = PC_W'(P3_BASE);
      default: PcTarget = PC_W'(P1_BASE);
    endcase
  end

  // Launch sequencer. Every output is computed for the state being entered,
  // so the outputs change on the same edge as the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      Ack        <= 1'b0;
      Run        <= 1'b0;
      PcLoad     <= 1'b0;
      ProgIdx    <= 2'd0;
      CycleCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state      <= LOAD;
            PcLoad     <= 1'b1;
            CycleCount <= '0;
          end
        end
        LOAD: begin
          // Keep the PC pinned for as long as the host holds Start high.
          CycleCount <= '0;
          if (!Start) begin
            state  <= RUN;
            PcLoad <= 1'b0;
            Run    <= 1'b1;
          end
        end
        RUN: begin
          if (Start) begin
            // A restart takes priority over a done seen in the same cycle.
            // The program index is not advanced.
            state      <= LOAD;
            Run        <= 1'b0;
            PcLoad     <= 1'b1;
            CycleCount <= '0;
          end else begin
            // This cycle is counted, including the cycle that carries DoneInstr.
            // The count saturates at all-ones instead of wrapping.
            if (CycleCount != '1) begin
              CycleCount <= CycleCount + 1'b1;
            end
            if (DoneInstr) begin
              state   <= DONE;
              Run     <= 1'b0;
              Ack     <= 1'b1;
              ProgIdx <= (ProgIdx == LAST_IDX) ? 2'd0 : ProgIdx + 2'd1;
            end
          end
        end
        DONE: begin
          if (Start) begin
            state      <= LOAD;
            Ack        <= 1'b0;
            PcLoad     <= 1'b1;
            CycleCount <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          Ack    <= 1'b0;
          Run    <= 1'b0;
          PcLoad <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl. It drives a 16-bit counter instance and a 4-bit counter instance in lockstep.
// Each cycle, outputs are compared with a phase-level reference model.
// Stimulus is directed scenarios followed by a randomized Start/DoneInstr/Reset stream.
module tb_run_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        DoneInstr = 1'b0;

  logic        ack_a, run_a, pcload_a;
  logic [9:0]  target_a;
  logic [1:0]  idx_a;
  logic [15:0] count_a;

  logic        ack_b, run_b, pcload_b;
  logic [9:0]  target_b;
  logic [1:0]  idx_b;
  logic [3:0]  count_b;

  int passed = 0;
  int total  = 0;

  // Reference model: what the program launcher is doing, which program is selected,
  // and how many run cycles have elapsed (unbounded; saturation is applied when checking).
  localparam int PH_IDLE = 0, PH_LOADING = 1, PH_RUNNING = 2, PH_FINISHED = 3;
  int ph   = PH_IDLE;
  int prog = 0;
  int runs = 0;

  run_ctrl #(.CNT_W(16)) dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .DoneInstr(DoneInstr),
    .Ack(ack_a), .Run(run_a), .PcLoad(pcload_a), .PcTarget(target_a),
    .ProgIdx(idx_a), .CycleCount(count_a)
  );

  run_ctrl #(.CNT_W(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .DoneInstr(DoneInstr),
    .Ack(ack_b), .Run(run_b), .PcLoad(pcload_b), .PcTarget(target_b),
    .ProgIdx(idx_b), .CycleCount(count_b)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // Advance the model by one clock from the sampled inputs.
  task automatic model_step(input logic rst, input logic st, input logic dn);
    if (rst) begin
      ph = PH_IDLE; prog = 0; runs = 0;
    end else if (ph == PH_IDLE) begin
      if (st) begin ph = PH_LOADING; runs = 0; end
    end else if (ph == PH_LOADING) begin
      runs = 0;
      if (!st) ph = PH_RUNNING;
    end else if (ph == PH_RUNNING) begin
      if (st) begin
        ph = PH_LOADING; runs = 0;
      end else begin
        runs = runs + 1;
        if (dn) begin ph = PH_FINISHED; prog = (prog + 1) % 3; end
      end
    end else begin
      if (st) begin ph = PH_LOADING; runs = 0; end
    end
  endtask

  task automatic check_all();
    check("a_ack",    32'(ack_a),    32'(ph == PH_FINISHED));
    check("a_run",    32'(run_a),    32'(ph == PH_RUNNING));
    check("a_pcload", 32'(pcload_a), 32'(ph == PH_LOADING));
    check("a_idx",    32'(idx_a),    32'(prog));
    check("a_target", 32'(target_a), 32'(prog * 256));
    check("a_count",  32'(count_a),  32'(sat(runs, 16)));
    check("b_ack",    32'(ack_b),    32'(ph == PH_FINISHED));
    check("b_run",    32'(run_b),    32'(ph == PH_RUNNING));
    check("b_pcload", 32'(pcload_b), 32'(ph == PH_LOADING));
    check("b_idx",    32'(idx_b),    32'(prog));
    check("b_target", 32'(target_b), 32'(prog * 256));
    check("b_count",  32'(count_b),  32'(sat(runs, 4)));
  endtask

  // One clock: inputs are applied at the falling edge, and results are checked at the next falling edge.
  task automatic cyc(input logic rst, input logic st, input logic dn);
    Reset = rst; Start = st; DoneInstr = dn;
    @(posedge Clk);
    model_step(rst, st, dn);
    @(negedge Clk);
    check_all();
  endtask

  task automatic launch();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic rs, st, dn;
    @(negedge Clk);

    // Reset for two cycles, then check the reset state.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("rst_run", 32'(run_a), 32'd0);
    check("rst_cnt", 32'(count_a), 32'd0);

    // Scenario 1: a one-cycle Start gives one cycle of PcLoad at base 0, then Run.
    cyc(1'b0, 1'b1, 1'b0);
    check("t1_pcload", 32'(pcload_a), 32'd1);
    check("t1_target", 32'(target_a), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("t1_run", 32'(run_a), 32'd1);
    check("t1_pcload_off", 32'(pcload_a), 32'd0);

    // Scenario 2: five run cycles, then DoneInstr.
    run_n(5);
    cyc(1'b0, 1'b0, 1'b1);
    check("t2_ack", 32'(ack_a), 32'd1);
    check("t2_run", 32'(run_a), 32'd0);
    check("t2_cnt", 32'(count_a), 32'd6);
    check("t2_idx", 32'(idx_a), 32'd1);
    check("t2_target", 32'(target_a), 32'd256);
    run_n(3);
    check("t2_frozen", 32'(count_a), 32'd6);

    // Scenario 3: run P2 and P3 to completion, then check the wrap back to P1.
    launch();
    check("t3_target_p2", 32'(target_a), 32'd256);
    run_n(2); cyc(1'b0, 1'b0, 1'b1);
    check("t3_target_p3", 32'(target_a), 32'd512);
    launch();
    run_n(1); cyc(1'b0, 1'b0, 1'b1);
    check("t3_wrap_idx", 32'(idx_a), 32'd0);
    check("t3_wrap_target", 32'(target_a), 32'd0);
    cyc(1'b0, 1'b1, 1'b0);
    check("t3_ack_drop", 32'(ack_a), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);

    // Scenario 4: Start and DoneInstr together while running. Start wins.
    run_n(2);
    cyc(1'b0, 1'b1, 1'b1);
    check("t4_pcload", 32'(pcload_a), 32'd1);
    check("t4_ack", 32'(ack_a), 32'd0);
    check("t4_idx", 32'(idx_a), 32'd0);
    check("t4_cnt", 32'(count_a), 32'd0);
    // Holding Start keeps PcLoad asserted.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);
    check("t4_hold", 32'(pcload_a), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);

    // Scenario 5: move to program 2, then reset in the middle of the run.
    run_n(1); cyc(1'b0, 1'b0, 1'b1);
    launch(); run_n(1); cyc(1'b0, 1'b0, 1'b1);
    launch(); run_n(3);
    check("t5_idx2", 32'(idx_a), 32'd2);
    cyc(1'b1, 1'b0, 1'b0);
    check("t5_run", 32'(run_a), 32'd0);
    check("t5_idx", 32'(idx_a), 32'd0);
    check("t5_cnt", 32'(count_a), 32'd0);
    cyc(1'b0, 1'b0, 1'b1);
    check("t5_ignore_done", 32'(ack_a), 32'd0);

    // Scenario 6: a 20-cycle run saturates the 4-bit counter.
    launch();
    run_n(19);
    cyc(1'b0, 1'b0, 1'b1);
    check("t6_sat4", 32'(count_b), 32'd15);
    check("t6_cnt16", 32'(count_a), 32'd20);
    check("t6_ack", 32'(ack_b), 32'd1);

    // Randomized Start/DoneInstr/Reset stream.
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 79) == 0);
      st = ($urandom_range(0, 9) == 0);
      dn = ($urandom_range(0, 5) == 0);
      cyc(rs, st, dn);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
